// File: rtl/btn_sched_pkg.sv
// btn_sched_pkg
//   Shared definitions for the button debounce scheduler: the scheduler
//   state enumeration and helpers that size the shared stability counter
//   and the button index from the block parameters.
package btn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILTER = 2'd1,
    COMMIT = 2'd2
  } sched_state_t;

  localparam int DEFAULT_BTN_COUNT      = 4;
  localparam int DEFAULT_DEBOUNCE_TICKS = 10000;

  // Counter must hold DEBOUNCE_TICKS-1; never narrower than one bit.
  function automatic int cnt_width(input int ticks);
    int w;
    if (ticks < 2) w = 1;
    else           w = $clog2(ticks);
    return w;
  endfunction

  // Index width for BTN_COUNT buttons; never narrower than one bit.
  function automatic int idx_width(input int count);
    int w;
    if (count < 2) w = 1;
    else           w = $clog2(count);
    return w;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// btn_sync
//   Two-flop synchronizer for one asynchronous button level.
//   Ports:
//     clk      - rising-edge clock
//     rst      - synchronous active-high reset (both flops cleared to 0)
//     async_in - raw asynchronous level
//     sync_out - level after two register stages
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
    end
  end

  assign sync_out = sync_r;

endmodule

// File: rtl/btn_debounce_scheduler.sv
// btn_debounce_scheduler
//   Debounces BTN_COUNT buttons with a single time-shared stability counter.
//   A button whose synchronized level differs from its debounced level is
//   granted the counter (round-robin from rrPtr); if it stays different for
//   DEBOUNCE_TICKS cycles its debounced level toggles, otherwise the grant
//   is abandoned and the next button gets a turn.
//   Ports:
//     clockSource  - single rising-edge clock
//     reset        - synchronous active-high reset
//     rawButtons   - asynchronous bouncing levels
//     buttonState  - registered debounced levels
//     pressPulse   - one-cycle pulse on an accepted 0->1
//     releasePulse - one-cycle pulse on an accepted 1->0
//     busy         - counter granted (FILTER or COMMIT)
//     activeIndex  - granted button index, 0 when idle
//   Build option: BTN_SCHED_EVENTS_EN defined drives pressPulse/releasePulse;
//   undefined ties both to zero (buttonState behaviour is unchanged).
module btn_debounce_scheduler
  import btn_sched_pkg::*;
#(
  parameter int BTN_COUNT      = DEFAULT_BTN_COUNT,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
  input  logic                             clockSource,
  input  logic                             reset,
  input  logic [BTN_COUNT-1:0]             rawButtons,
  output logic [BTN_COUNT-1:0]             buttonState,
  output logic [BTN_COUNT-1:0]             pressPulse,
  output logic [BTN_COUNT-1:0]             releasePulse,
  output logic                             busy,
  output logic [idx_width(BTN_COUNT)-1:0]  activeIndex
);

  localparam int CW = cnt_width(DEBOUNCE_TICKS);
  localparam int IW = idx_width(BTN_COUNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [IW-1:0] IDX_LAST = IW'(BTN_COUNT - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(32'd1);

  sched_state_t         state_r, state_next;
  logic [CW-1:0]        cnt_r, cnt_next;
  logic [IW-1:0]        rr_r, rr_next;
  logic [IW-1:0]        sel_r, sel_next;
  logic [BTN_COUNT-1:0] btn_r, btn_next;
  logic                 busy_r;
  logic [IW-1:0]        active_r;
  logic [BTN_COUNT-1:0] sync_raw;
  logic [BTN_COUNT-1:0] pending;
  logic                 grant_found;
  logic [IW-1:0]        grant_idx;

  // Round-robin successor; explicit wrap so non-power-of-two counts work.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    logic [IW-1:0] res;
    if (idx == IDX_LAST) res = '0;
    else                 res = idx + IDX_ONE;
    return res;
  endfunction

  for (genvar g = 0; g < BTN_COUNT; g++) begin : g_sync
    btn_sync u_sync (
      .clk      (clockSource),
      .rst      (reset),
      .async_in (rawButtons[g]),
      .sync_out (sync_raw[g])
    );
  end

  // First pending button at or after rrPtr, scanning with wrap-around.
  always_comb begin
    int cand;
    cand        = 0;
    pending     = sync_raw ^ btn_r;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < BTN_COUNT; i++) begin
      cand = int'(rr_r) + i;
      if (cand >= BTN_COUNT) cand = cand - BTN_COUNT;
      else                   cand = cand;
      if (!grant_found && pending[cand[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IW-1:0];
      end else begin
        grant_found = grant_found;
      end
    end
  end

  // Scheduler next-state and datapath updates.
  always_comb begin
    state_next = state_r;
    cnt_next   = cnt_r;
    rr_next    = rr_r;
    sel_next   = sel_r;
    btn_next   = btn_r;
    case (state_r)
      IDLE: begin
        if (grant_found) begin
          state_next = FILTER;
          sel_next   = grant_idx;
          cnt_next   = '0;
        end else begin
          state_next = IDLE;
        end
      end
      FILTER: begin
        // Level reverted to the debounced value: give up this grant.
        if (sync_raw[sel_r] == btn_r[sel_r]) begin
          state_next = IDLE;
          rr_next    = wrap_inc(sel_r);
        end else if (cnt_r == CNT_LAST) begin
          state_next = COMMIT;
        end else begin
          cnt_next = cnt_r + CNT_ONE;
        end
      end
      COMMIT: begin
        btn_next[sel_r] = ~btn_r[sel_r];
        rr_next         = wrap_inc(sel_r);
        state_next      = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Scheduler state, counter and debounced-level registers.
  always_ff @(posedge clockSource) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      rr_r     <= '0;
      sel_r    <= '0;
      btn_r    <= '0;
      busy_r   <= 1'b0;
      active_r <= '0;
    end else begin
      state_r  <= state_next;
      cnt_r    <= cnt_next;
      rr_r     <= rr_next;
      sel_r    <= sel_next;
      btn_r    <= btn_next;
      busy_r   <= (state_next != IDLE);
      active_r <= (state_next != IDLE) ? sel_next : '0;
    end
  end

  assign buttonState = btn_r;
  assign busy        = busy_r;
  assign activeIndex = active_r;

`ifdef BTN_SCHED_EVENTS_EN
  logic [BTN_COUNT-1:0] press_r, release_r;
  logic [BTN_COUNT-1:0] press_next, release_next;

  // Edge pulses for the commit cycle; direction follows the new level.
  always_comb begin
    press_next   = '0;
    release_next = '0;
    if (state_r == COMMIT) begin
      if (btn_r[sel_r]) release_next[sel_r] = 1'b1;
      else              press_next[sel_r]   = 1'b1;
    end else begin
      press_next   = '0;
      release_next = '0;
    end
  end

  // One-cycle event pulse registers.
  always_ff @(posedge clockSource) begin
    if (reset) begin
      press_r   <= '0;
      release_r <= '0;
    end else begin
      press_r   <= press_next;
      release_r <= release_next;
    end
  end

  assign pressPulse   = press_r;
  assign releasePulse = release_r;
`else
  assign pressPulse   = '0;
  assign releasePulse = '0;
`endif

endmodule

// File: tb/tb_btn_debounce_scheduler.sv
// Self-checking bench for btn_debounce_scheduler (BTN_COUNT=4,
// DEBOUNCE_TICKS=8): directed scenarios with literal timing expectations,
// then random button activity checked every cycle against a reference model.
module tb_btn_debounce_scheduler;

  localparam int N = 4;
  localparam int T = 8;
`ifdef BTN_SCHED_EVENTS_EN
  localparam logic EV = 1'b1;
`else
  localparam logic EV = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] raw;
  logic [N-1:0] buttonState, pressPulse, releasePulse;
  logic         busy;
  logic [1:0]   activeIndex;

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;

  btn_debounce_scheduler #(.BTN_COUNT(N), .DEBOUNCE_TICKS(T)) dut (
    .clockSource  (clk),
    .reset        (reset),
    .rawButtons   (raw),
    .buttonState  (buttonState),
    .pressPulse   (pressPulse),
    .releasePulse (releasePulse),
    .busy         (busy),
    .activeIndex  (activeIndex)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a raw level counts once it has been seen through two
  // sampling edges; a granted button must disagree with its debounced value
  // for T+1 consecutive grant cycles, then flips on the following edge.
  logic [N-1:0] m_s1, m_s2, m_btn, m_press, m_rel;
  int m_grant = -1;
  int m_held  = 0;
  int m_rr    = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_btn = '0; m_press = '0; m_rel = '0;
      m_grant = -1; m_held = 0; m_rr = 0;
    end else begin
      m_press = '0;
      m_rel   = '0;
      if (m_grant < 0) begin
        for (int i = 0; i < N; i++) begin
          int j;
          j = (m_rr + i) % N;
          if (m_grant < 0 && m_s2[j] != m_btn[j]) begin
            m_grant = j;
            m_held  = 0;
          end
        end
      end else if (m_held == T) begin
        m_btn[m_grant] = ~m_btn[m_grant];
        if (m_btn[m_grant]) m_press[m_grant] = 1'b1;
        else                m_rel[m_grant]   = 1'b1;
        m_rr    = (m_grant + 1) % N;
        m_grant = -1;
      end else if (m_s2[m_grant] == m_btn[m_grant]) begin
        m_rr    = (m_grant + 1) % N;
        m_grant = -1;
      end else begin
        m_held++;
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("buttonState", buttonState, m_btn);
      check("pressPulse", pressPulse, EV ? m_press : '0);
      check("releasePulse", releasePulse, EV ? m_rel : '0);
      check("busy", busy, m_grant >= 0);
      check("activeIndex", activeIndex, (m_grant >= 0) ? m_grant : 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int bc;
    int first [N];
    reset = 1'b1;
    raw   = '0;
    step(3);
    cmp_en = 1'b1;
    check("rst_state", buttonState, 0);
    check("rst_busy", busy, 0);
    check("rst_index", activeIndex, 0);
    reset = 1'b0;
    step(5);

    // Clean press on bit0: toggle on edge 12, busy for 9 cycles.
    raw[0] = 1'b1;
    bc = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k <= 11) bc += int'(busy);
      if (k == 11) check("press0_before", buttonState[0], 0);
      if (k == 12) begin
        check("press0_edge12", buttonState[0], 1);
        check("press0_pulse", pressPulse[0], EV);
      end
    end
    check("press0_busy_cycles", bc, 9);
    raw[0] = 1'b0;
    step(20);
    check("release0", buttonState, 0);

    // Bit1 bounces then settles high.
    for (int b = 0; b < 4; b++) begin
      raw[1] = (b % 2 == 0);
      step(3);
      check("bounce_no_toggle", buttonState[1], 0);
    end
    raw[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k == 11) check("bounce_before", buttonState[1], 0);
      if (k == 12) check("bounce_edge12", buttonState[1], 1);
    end

    // Reset, then bits 0,2,3 rise together: served 0,2,3 ten cycles apart.
    reset = 1'b1;
    raw   = '0;
    step(2);
    check("rst2_state", buttonState, 0);
    reset = 1'b0;
    raw   = 4'b1101;
    for (int i = 0; i < N; i++) first[i] = -1;
    for (int k = 1; k <= 34; k++) begin
      step(1);
      for (int i = 0; i < N; i++)
        if (first[i] < 0 && buttonState[i]) first[i] = k;
    end
    check("rr_bit0", first[0], 12);
    check("rr_bit2", first[2], 22);
    check("rr_bit3", first[3], 32);
    check("rr_bit1", first[1], -1);

    // After bit3 commit the pointer wraps: bit0 is granted before bit3.
    raw = 4'b0100;
    step(3);
    check("wrap_busy", busy, 1);
    check("wrap_index", activeIndex, 0);
    step(30);
    check("wrap_final", buttonState, 4'b0100);

    // Reset in the middle of filtering bit2.
    reset = 1'b1;
    raw   = '0;
    step(2);
    reset = 1'b0;
    raw   = 4'b0100;
    step(8);
    check("midf_index", activeIndex, 2);
    reset = 1'b1;
    step(1);
    check("midf_state", buttonState, 0);
    check("midf_busy", busy, 0);
    check("midf_pulse", pressPulse, 0);
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k == 11) check("after_rst_before", buttonState[2], 0);
      if (k == 12) begin
        check("after_rst_edge12", buttonState[2], 1);
        check("after_rst_pulse", pressPulse[2], EV);
      end
    end

    // Random activity with busy and quiet phases and rare resets.
    for (int c = 0; c < 4000; c++) begin
      int r;
      int b;
      step(1);
      r = $urandom_range(0, 99);
      b = $urandom_range(0, N - 1);
      if (r < ((c / 250) % 2 == 0 ? 8 : 2)) raw[b] = ~raw[b];
      if ($urandom_range(0, 799) == 0) reset = 1'b1;
      else                              reset = 1'b0;
    end
    reset = 1'b0;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btn_debounce_scheduler.md
BTN_DEBOUNCE_SCHEDULER -- requirements
Module: btn_debounce_scheduler

Interface
REQ-001 SHALL have parameter BTN_COUNT, default 4: number of button inputs (2..16).
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 10000: stable cycles required to accept a change (>=2).
REQ-003 SHALL have port clockSource  input  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port rawButtons  input  BTN_COUNT: asynchronous, bouncing button levels.
REQ-006 SHALL have port buttonState  output  BTN_COUNT: registered debounced levels.
REQ-007 SHALL have port pressPulse  output  BTN_COUNT: one-cycle pulse on accepted 0->1.
REQ-008 SHALL have port releasePulse  output  BTN_COUNT: one-cycle pulse on accepted 1->0.
REQ-009 SHALL have port busy  output  1: high while the shared counter is granted (FILTER or COMMIT).
REQ-010 SHALL have port activeIndex  output  clog2(BTN_COUNT): index of the granted button; 0 when idle.

Function
REQ-011 SHALL pass each rawButtons bit through a two-flop synchronizer; only synchronized values (syncRaw) are used.
REQ-012 SHALL own exactly one stability counter, width clog2(DEBOUNCE_TICKS), time-shared among all buttons.
REQ-013 SHALL implement states IDLE, FILTER, COMMIT.
REQ-014 IDLE: pending = syncRaw XOR buttonState; if any bit set, grant the first pending index at or after rrPtr (wrapping), load counter 0, go to FILTER; otherwise stay.
REQ-015 FILTER: if syncRaw[sel] == buttonState[sel] -> abort, rrPtr = sel+1 (mod BTN_COUNT), go to IDLE, no state change, no pulse.
REQ-016 FILTER: else if counter == DEBOUNCE_TICKS-1 -> go to COMMIT; else counter increments.
REQ-017 COMMIT: toggle buttonState[sel]; assert pressPulse[sel] or releasePulse[sel] (new value) for exactly one cycle; rrPtr = sel+1 (mod BTN_COUNT); go to IDLE.
REQ-018 Uncontended latency: buttonState changes on rising edge DEBOUNCE_TICKS+4 counting the first edge sampling the new raw level as edge 1.
REQ-019 Non-granted buttons SHALL hold their buttonState while waiting; their changes are evaluated only when granted.
REQ-020 Simultaneous pending changes SHALL be served one at a time in round-robin order; no button starves (worst-case wait BTN_COUNT-1 grants).
REQ-021 A button whose raw level reverts while waiting SHALL never be granted and SHALL produce no pulse.
REQ-022 rrPtr wraps from BTN_COUNT-1 to 0.
REQ-023 At most one bit across pressPulse|releasePulse SHALL be high in any cycle.

Reset
REQ-024 On reset: state IDLE, counter 0, rrPtr 0, synchronizers 0, buttonState 0, all pulses 0, busy 0, activeIndex 0.
REQ-025 Reset asserted mid-FILTER or mid-COMMIT SHALL abort with no pulse and no toggle.
REQ-026 After reset release, a raw input held high SHALL be debounced normally and produce one pressPulse.

Configuration
REQ-027 Macro BTN_SCHED_EVENTS_EN: defined -> pressPulse/releasePulse driven per REQ-017; undefined -> both tied to all-zero and their registers not synthesized; buttonState behaviour identical in both builds.

Structure
REQ-028 Package btn_sched_pkg SHALL hold the state enumeration (IDLE/FILTER/COMMIT) and the counter/index width helper constants.
REQ-029 Sub-module btn_sync (per-bit two-flop synchronizer, reset to 0) SHALL be instantiated BTN_COUNT times; all else in the top.

Verification (DEBOUNCE_TICKS=8, BTN_COUNT=4)
REQ-030 Clean press on bit0 after reset -> buttonState[0]=1 on edge 12, pressPulse[0] high exactly that one cycle, busy high 9 cycles.
REQ-031 Bit1 bounces 1,0,1,0 every 3 cycles then holds 1 -> no toggle during bounce; one pressPulse[1] 12 edges after final stable edge (at most one abort in between).
REQ-032 Bits 0,2,3 rise on same edge -> commits in order 0,2,3, spaced 10 cycles apart; never two pulses in one cycle.
REQ-033 rrPtr=3 after commit on bit3, then bits 0 and 3 change together -> bit0 granted first (wrap).
REQ-034 Reset asserted at FILTER count 5 on bit2 -> all outputs 0 next cycle, no pulse; raw still high -> pressPulse[2] 12 edges after reset release.
REQ-035 Build without BTN_SCHED_EVENTS_EN, repeat REQ-030 -> identical buttonState timing, pulses constantly 0.
